// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the execute stage and the
// multicycle multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MDOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             WriteHI;
  logic             WriteLO;
  logic [WIDTH-1:0] WriteData;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, MDOperation, A, B, WriteHI, WriteLO, WriteData,
    input  Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, MDOperation, A, B, WriteHI, WriteLO, WriteData,
    output Busy, Done, DivByZero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply / restoring divide on magnitudes, sign fixed up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [1:0]         op;
  logic [WIDTH-1:0]   opnd_b;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic               neg_a;
  logic               neg_b;
  logic               b_zero;
  logic [CW-1:0]      count;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes are taken only for the signed ops (MDOperation[0]=1).
  assign in_neg_a = bus.MDOperation[0] & bus.A[WIDTH-1];
  assign in_neg_b = bus.MDOperation[0] & bus.B[WIDTH-1];
  assign in_mag_a = in_neg_a ? -bus.A : bus.A;
  assign in_mag_b = in_neg_b ? -bus.B : bus.B;

  // acc = {upper accumulator, multiplier} for MUL, {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, opnd_b};
  assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
  assign quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op       <= '0;
      opnd_b   <= '0;
      a_raw    <= '0;
      acc      <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state    <= RUN;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            op       <= bus.MDOperation;
            a_raw    <= bus.A;
            opnd_b   <= in_mag_b;
            acc      <= {{WIDTH{1'b0}}, in_mag_a};
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            b_zero   <= (bus.B == '0);
            count    <= '0;
            // The multiplier, not the multiplicand, must sit in the low half.
            if (!bus.MDOperation[1]) begin
              opnd_b <= in_mag_a;
              acc    <= {{WIDTH{1'b0}}, in_mag_b};
            end
          end else begin
            if (bus.WriteHI) hi <= bus.WriteData;
            if (bus.WriteLO) lo <= bus.WriteData;
          end
        end
        RUN: begin
          acc   <= op[1] ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!op[1]) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi       <= a_raw;
            lo       <= '1;
            div_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = div_zero;
  assign bus.HI        = hi;
  assign bus.LO        = lo;

endmodule
